video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised, runtime-reprogrammable raster timing generator for the DVI/HDMI transmit path; replaces the fixed-mode rgb_timing + pixel_counter pair.
- Runs on the pixel clock. Drives hsync/vsync/blank, X/Y position and frame/line markers to the pattern generator and the rgb_to_dvi encoder.
- Timing config uses a valid/ready handshake into a shadow register. The shadow is applied only at a frame boundary, so mode changes never produce a torn frame.

Parameters:
- H_W, 12: horizontal counter/field width.
- V_W, 11: vertical counter/field width.
- DEF_H_ACT, DEF_H_FP, DEF_H_SYNC, DEF_H_BP; 1280, 110, 40, 220: reset horizontal timing in pixels.
- DEF_V_ACT, DEF_V_FP, DEF_V_SYNC, DEF_V_BP; 720, 5, 5, 20: reset vertical timing in lines.
- DEF_POL, 2'b11: reset sync polarity {vs_pol, hs_pol}; 1 = active-high.

Ports:
- i_clk  in  1  pixel clock
- i_arst_n  in  1  asynchronous active-low reset
- i_en  in  1  run enable
- i_cfg_valid  in  1  config request
- o_cfg_ready  out  1  shadow register free
- i_cfg_h  in  4*H_W  {act, fp, sync, bp}, act in MSBs
- i_cfg_v  in  4*V_W  {act, fp, sync, bp}, act in MSBs
- i_cfg_pol  in  2  {vs_pol, hs_pol}
- o_cfg_err  out  1  one-cycle pulse: config rejected
- o_cfg_pending  out  1  shadow holds an unapplied config
- o_hsync  out  1  horizontal sync, polarity-applied
- o_vsync  out  1  vertical sync, polarity-applied
- o_blank  out  1  1 outside active area
- o_x  out  H_W  horizontal position
- o_y  out  V_W  vertical position
- o_sof  out  1  start-of-frame pulse
- o_eol  out  1  end-of-active-line pulse

Behaviour:
- **Reset** (async assert, sync release):
  - counters h=0, v=0; working timing = DEF_*.
  - o_blank=1, o_x=0, o_y=0, o_sof=0, o_eol=0, o_cfg_err=0.
  - o_hsync=~DEF_POL[0], o_vsync=~DEF_POL[1].
  - o_cfg_ready=1, o_cfg_pending=0.
- **Totals and horizontal sequence**:
  - H_TOT = act+fp+sync+bp, computed in H_W+2 bits; V_TOT likewise in V_W+2 bits.
  - Horizontal order: active [0,act), front porch, sync, back porch.
  - h wraps H_TOT-1 -> 0. v increments on that wrap and wraps V_TOT-1 -> 0.
- **Sync and blank** (all derived combinationally from the counters):
  - hsync active when h is in [act+fp, act+fp+sync).
  - vsync active when v is in [vact+vfp, vact+vfp+vsync); vsync changes only at h=0.
  - blank = !(h<act && v<vact).
- **Output registration**: every output is registered, giving exactly 1 cycle latency from the counters.
  - o_x/o_y = h/v.
  - o_sof = (h==0 && v==0).
  - o_eol = (h==act-1 && v<vact).
- **i_en=0**:
  - counters hold.
  - o_blank forced 1, syncs at inactive level, o_sof=o_eol=0.
  - Resuming continues from the held position.
- **Config handshake**:
  - Accept occurs when i_cfg_valid && o_cfg_ready; o_cfg_ready = !o_cfg_pending.
  - Validation on accept: reject if any act or sync field is 0, or H_TOT > 2^H_W, or V_TOT > 2^V_W.
  - Reject: pulse o_cfg_err the next cycle; shadow unchanged; ready stays 1.
  - Valid: shadow loaded, o_cfg_pending=1 the next cycle.
- **Config apply**:
  - On the cycle h=H_TOT-1 && v=V_TOT-1 with i_en=1 and pending=1, the working timing is replaced by the shadow, pending clears and the counters go to 0.
  - The new frame starts with the new timing; the polarity change takes effect in that same next cycle.
  - If an accept and an apply coincide, this is impossible because ready=0 while pending.
- **Counter invariant**: counters never exceed the working totals; there is no out-of-range state.
- **Reset mid-frame**: immediate return to the reset state; the shadow is discarded.

Test Plan:
- Override defaults to H 8/2/3/3 (H_TOT=16) and V 4/1/1/2 (V_TOT=8), pol 2'b11, release reset:
  - o_sof exactly every 128 cycles.
  - o_hsync high for 3 cycles, starting 10 cycles after each line start.
  - o_blank low for 8 of every 16 cycles on lines 0-3.
  - o_vsync high for all of line 5.
- Same setup, check registered outputs: o_eol asserted exactly when o_x=7, on lines 0-3 only, and never on lines 4-7.
- Send config H 4/1/1/2, V 2/1/1/1, pol 2'b00 at mid-frame:
  - o_cfg_pending=1 and o_cfg_ready=0 until the frame ends.
  - Next frame: period = 8*5 = 40 cycles.
  - Syncs are active-low, i.e. idle level 1.
- Config with h sync=0, then config with H_TOT > 4096 (H_W=12):
  - o_cfg_err pulses once for each.
  - o_cfg_pending stays 0 and timing is unchanged.
- Drop i_en for 20 cycles at h=5, v=2: o_blank=1, syncs inactive, o_x frozen at 5; after re-enable, o_x resumes at 6.
- With a config pending, assert i_arst_n=0 for 1 cycle mid-line: all outputs return to reset values asynchronously, pending clears, and the default timing resumes.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Timing-configuration port of video_timing_gen.
// Handshake: the master holds i_cfg_valid and the payload (i_cfg_h, i_cfg_v,
// i_cfg_pol) stable until a rising clock edge sees i_cfg_valid && o_cfg_ready.
// That edge is the transfer. o_cfg_ready never depends on i_cfg_valid.
// The cycle after a transfer, o_cfg_err pulses if the payload was rejected,
// or o_cfg_pending rises if it was stored.
interface video_timing_gen_if #(
  parameter int H_W = 12,
  parameter int V_W = 11
);
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [4*H_W-1:0] i_cfg_h;
  logic [4*V_W-1:0] i_cfg_v;
  logic [1:0]       i_cfg_pol;
  logic             o_cfg_err;
  logic             o_cfg_pending;

  modport master (
    output i_cfg_valid, i_cfg_h, i_cfg_v, i_cfg_pol,
    input  o_cfg_ready, o_cfg_err, o_cfg_pending
  );

  modport slave (
    input  i_cfg_valid, i_cfg_h, i_cfg_v, i_cfg_pol,
    output o_cfg_ready, o_cfg_err, o_cfg_pending
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI/HDMI transmit path.
// Free-running h/v counters produce sync, blank, position and frame/line
// markers, all registered one cycle after the counters. A new mode is
// captured into a shadow register through the cfg port. The shadow is
// swapped into the working timing only on the last pixel of a frame, so
// the output never shows a torn frame.
module video_timing_gen #(
  parameter int         H_W        = 12,
  parameter int         V_W        = 11,
  parameter int         DEF_H_ACT  = 1280,
  parameter int         DEF_H_FP   = 110,
  parameter int         DEF_H_SYNC = 40,
  parameter int         DEF_H_BP   = 220,
  parameter int         DEF_V_ACT  = 720,
  parameter int         DEF_V_FP   = 5,
  parameter int         DEF_V_SYNC = 5,
  parameter int         DEF_V_BP   = 20,
  parameter logic [1:0] DEF_POL    = 2'b11
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic               i_en,
  video_timing_gen_if.slave  cfg,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_blank,
  output logic [H_W-1:0]     o_x,
  output logic [V_W-1:0]     o_y,
  output logic               o_sof,
  output logic               o_eol
);

  // Field order matches the cfg bus: act in the MSBs, bp in the LSBs.
  typedef struct packed {
    logic [H_W-1:0] act;
    logic [H_W-1:0] fp;
    logic [H_W-1:0] sync;
    logic [H_W-1:0] bp;
  } h_tim_t;

  typedef struct packed {
    logic [V_W-1:0] act;
    logic [V_W-1:0] fp;
    logic [V_W-1:0] sync;
    logic [V_W-1:0] bp;
  } v_tim_t;

  // Totals need two extra bits so that four full-width fields cannot wrap.
  localparam int HX = H_W + 2;
  localparam int VX = V_W + 2;

  localparam h_tim_t H_DEF = '{act: H_W'(DEF_H_ACT), fp: H_W'(DEF_H_FP),
                               sync: H_W'(DEF_H_SYNC), bp: H_W'(DEF_H_BP)};
  localparam v_tim_t V_DEF = '{act: V_W'(DEF_V_ACT), fp: V_W'(DEF_V_FP),
                               sync: V_W'(DEF_V_SYNC), bp: V_W'(DEF_V_BP)};

  h_tim_t         h_wrk, h_shd, h_in;
  v_tim_t         v_wrk, v_shd, v_in;
  logic [1:0]     pol_wrk, pol_shd;
  logic           pending;
  logic           cfg_err;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  // Working-timing boundaries in widened arithmetic.
  logic [HX-1:0] h_hs_start, h_hs_end, h_tot, h_cnt_x;
  logic [VX-1:0] v_vs_start, v_vs_end, v_tot, v_cnt_x;
  logic          h_last, v_last, hs_act, vs_act, in_active, sof_c, eol_c;
  logic [HX-1:0] h_in_tot;
  logic [VX-1:0] v_in_tot;
  logic          accept, cfg_bad, apply;

  assign h_cnt_x    = {2'b00, h_cnt};
  assign v_cnt_x    = {2'b00, v_cnt};
  assign h_hs_start = HX'(h_wrk.act) + HX'(h_wrk.fp);
  assign h_hs_end   = h_hs_start + HX'(h_wrk.sync);
  assign h_tot      = h_hs_end + HX'(h_wrk.bp);
  assign v_vs_start = VX'(v_wrk.act) + VX'(v_wrk.fp);
  assign v_vs_end   = v_vs_start + VX'(v_wrk.sync);
  assign v_tot      = v_vs_end + VX'(v_wrk.bp);

  assign h_last    = (h_cnt_x == h_tot - HX'(1));
  assign v_last    = (v_cnt_x == v_tot - VX'(1));
  // v only moves when h wraps, so vsync naturally changes only at h=0.
  assign hs_act    = (h_cnt_x >= h_hs_start) && (h_cnt_x < h_hs_end);
  assign vs_act    = (v_cnt_x >= v_vs_start) && (v_cnt_x < v_vs_end);
  assign in_active = (h_cnt < h_wrk.act) && (v_cnt < v_wrk.act);
  assign sof_c     = (h_cnt == '0) && (v_cnt == '0);
  assign eol_c     = (h_cnt == h_wrk.act - H_W'(1)) && (v_cnt < v_wrk.act);

  // Incoming request validation: zero act/sync or a total that would not
  // fit the counter is refused.
  assign h_in     = h_tim_t'(cfg.i_cfg_h);
  assign v_in     = v_tim_t'(cfg.i_cfg_v);
  assign h_in_tot = HX'(h_in.act) + HX'(h_in.fp) + HX'(h_in.sync) + HX'(h_in.bp);
  assign v_in_tot = VX'(v_in.act) + VX'(v_in.fp) + VX'(v_in.sync) + VX'(v_in.bp);
  assign cfg_bad  = (h_in.act == '0) || (h_in.sync == '0) ||
                    (v_in.act == '0) || (v_in.sync == '0) ||
                    (h_in_tot > HX'(1 << H_W)) || (v_in_tot > VX'(1 << V_W));

  // Ready is low while pending, so accept and apply can never coincide.
  assign accept = cfg.i_cfg_valid && !pending;
  assign apply  = i_en && pending && h_last && v_last;

  assign cfg.o_cfg_ready   = !pending;
  assign cfg.o_cfg_pending = pending;
  assign cfg.o_cfg_err     = cfg_err;

  // Shadow capture, frame-boundary apply and the reject pulse.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      h_wrk   <= H_DEF;
      v_wrk   <= V_DEF;
      pol_wrk <= DEF_POL;
      h_shd   <= H_DEF;
      v_shd   <= V_DEF;
      pol_shd <= DEF_POL;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && cfg_bad;
      if (accept && !cfg_bad) begin
        h_shd   <= h_in;
        v_shd   <= v_in;
        pol_shd <= cfg.i_cfg_pol;
        pending <= 1'b1;
      end else if (apply) begin
        h_wrk   <= h_shd;
        v_wrk   <= v_shd;
        pol_wrk <= pol_shd;
        pending <= 1'b0;
      end
    end
  end

  // Raster counters; they hold while disabled and wrap at the working totals.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_hsync <= ~DEF_POL[0];
      o_vsync <= ~DEF_POL[1];
      o_blank <= 1'b1;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end else begin
      o_x <= h_cnt;
      o_y <= v_cnt;
      if (i_en) begin
        o_hsync <= hs_act ? pol_wrk[0] : ~pol_wrk[0];
        o_vsync <= vs_act ? pol_wrk[1] : ~pol_wrk[1];
        o_blank <= !in_active;
        o_sof   <= sof_c;
        o_eol   <= eol_c;
      end else begin
        o_hsync <= ~pol_wrk[0];
        o_vsync <= ~pol_wrk[1];
        o_blank <= 1'b1;
        o_sof   <= 1'b0;
        o_eol   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small default timing, a frame-position model
// feeding an expected queue, and directed checks of the raster, enable,
// config handshake and reset behaviour.
module tb_video_timing_gen;
  localparam int H_W = 12;
  localparam int V_W = 11;
  localparam int W   = 31;
  localparam int D_HA = 8, D_HF = 2, D_HS = 3, D_HB = 3;
  localparam int D_VA = 4, D_VF = 1, D_VS = 1, D_VB = 2;

  // ---------------- clock / reset / DUT ----------------
  logic           i_clk = 1'b0;
  logic           i_arst_n = 1'b0;
  logic           i_en = 1'b0;
  logic           o_hsync, o_vsync, o_blank, o_sof, o_eol;
  logic [H_W-1:0] o_x;
  logic [V_W-1:0] o_y;

  video_timing_gen_if #(.H_W(H_W), .V_W(V_W)) cfg_if ();

  video_timing_gen #(
    .H_W(H_W), .V_W(V_W),
    .DEF_H_ACT(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB),
    .DEF_V_ACT(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB),
    .DEF_POL(2'b11)
  ) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_en(i_en), .cfg(cfg_if),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank),
    .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] obs_vec;
  assign obs_vec = {o_hsync, o_vsync, o_blank, o_x, o_y, o_sof, o_eol,
                    cfg_if.o_cfg_ready, cfg_if.o_cfg_pending, cfg_if.o_cfg_err};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [W-1:0] exp_q[$];
  int   m_ha, m_hf, m_hs, m_hb, m_va, m_vf, m_vs, m_vb;
  int   s_ha, s_hf, s_hs, s_hb, s_va, s_vf, s_vs, s_vb;
  logic [1:0] m_pol, s_pol;
  logic m_pend, m_pend_pre, m_acc, m_err, e_hs, e_vs, e_bl, e_sof, e_eol;
  int   m_pos, m_htot, m_vtot, m_h, m_v;
  int   c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb;

  // The model tracks a linear position inside the frame and derives h/v from it.
  always @(posedge i_clk) begin
    if (!i_arst_n) begin
      m_ha = D_HA; m_hf = D_HF; m_hs = D_HS; m_hb = D_HB;
      m_va = D_VA; m_vf = D_VF; m_vs = D_VS; m_vb = D_VB;
      m_pol = 2'b11; m_pend = 1'b0; m_pos = 0;
      exp_q.delete();
    end else begin
      m_htot = m_ha + m_hf + m_hs + m_hb;
      m_vtot = m_va + m_vf + m_vs + m_vb;
      m_h = m_pos % m_htot;
      m_v = m_pos / m_htot;
      if (i_en) begin
        e_hs  = (m_h >= m_ha + m_hf && m_h < m_ha + m_hf + m_hs) ? m_pol[0] : ~m_pol[0];
        e_vs  = (m_v >= m_va + m_vf && m_v < m_va + m_vf + m_vs) ? m_pol[1] : ~m_pol[1];
        e_bl  = !(m_h < m_ha && m_v < m_va);
        e_sof = (m_pos == 0);
        e_eol = (m_h == m_ha - 1) && (m_v < m_va);
      end else begin
        e_hs = ~m_pol[0]; e_vs = ~m_pol[1]; e_bl = 1'b1; e_sof = 1'b0; e_eol = 1'b0;
      end
      c_ha = int'(cfg_if.i_cfg_h[4*H_W-1 -: H_W]);
      c_hf = int'(cfg_if.i_cfg_h[3*H_W-1 -: H_W]);
      c_hs = int'(cfg_if.i_cfg_h[2*H_W-1 -: H_W]);
      c_hb = int'(cfg_if.i_cfg_h[H_W-1:0]);
      c_va = int'(cfg_if.i_cfg_v[4*V_W-1 -: V_W]);
      c_vf = int'(cfg_if.i_cfg_v[3*V_W-1 -: V_W]);
      c_vs = int'(cfg_if.i_cfg_v[2*V_W-1 -: V_W]);
      c_vb = int'(cfg_if.i_cfg_v[V_W-1:0]);
      m_pend_pre = m_pend;
      m_acc = cfg_if.i_cfg_valid && !m_pend_pre;
      m_err = m_acc && (c_ha == 0 || c_hs == 0 || c_va == 0 || c_vs == 0 ||
                        c_ha + c_hf + c_hs + c_hb > (1 << H_W) ||
                        c_va + c_vf + c_vs + c_vb > (1 << V_W));
      if (i_en) begin
        if (m_pos == m_htot * m_vtot - 1) begin
          m_pos = 0;
          if (m_pend_pre) begin
            m_ha = s_ha; m_hf = s_hf; m_hs = s_hs; m_hb = s_hb;
            m_va = s_va; m_vf = s_vf; m_vs = s_vs; m_vb = s_vb;
            m_pol = s_pol; m_pend = 1'b0;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
      if (m_acc && !m_err) begin
        s_ha = c_ha; s_hf = c_hf; s_hs = c_hs; s_hb = c_hb;
        s_va = c_va; s_vf = c_vf; s_vs = c_vs; s_vb = c_vb;
        s_pol = cfg_if.i_cfg_pol; m_pend = 1'b1;
      end
      exp_q.push_back({e_hs, e_vs, e_bl, H_W'(m_h), V_W'(m_v), e_sof, e_eol,
                       ~m_pend, m_pend, m_err});
    end
  end

  // Every registered output is compared against the model one cycle later.
  always @(negedge i_clk) begin
    if (i_arst_n && exp_q.size() > 0) chk("sb", obs_vec, exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  function automatic logic [4*H_W-1:0] pack_h(input int a, f, s, b);
    return {H_W'(a), H_W'(f), H_W'(s), H_W'(b)};
  endfunction

  function automatic logic [4*V_W-1:0] pack_v(input int a, f, s, b);
    return {V_W'(a), V_W'(f), V_W'(s), V_W'(b)};
  endfunction

  // Drives one request for one cycle; returns on the sample after the transfer edge.
  task automatic send_cfg(input logic [4*H_W-1:0] h, input logic [4*V_W-1:0] v,
                          input logic [1:0] pol);
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_h     = h;
    cfg_if.i_cfg_v     = v;
    cfg_if.i_cfg_pol   = pol;
    @(negedge i_clk);
    cfg_if.i_cfg_valid = 1'b0;
  endtask

  task automatic wait_xy(input string tag, input int x, input int y, input int budget);
    int n = 0;
    while (!(o_x == H_W'(x) && o_y == V_W'(y)) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, (o_x == H_W'(x) && o_y == V_W'(y)), 1);
  endtask

  // Finds the next sof and returns the distance to the following one (-1 on timeout).
  task automatic sof_period(output int p);
    int n = 0;
    @(negedge i_clk);
    while (!o_sof && n < 2000) begin @(negedge i_clk); n++; end
    if (!o_sof) begin p = -1; return; end
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_sof && n < 2000);
    p = o_sof ? n : -1;
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0]     rst_vec;
  logic [4*H_W-1:0] eh_tab [3];
  logic [4*V_W-1:0] ev_tab [3];
  int per, bad, hs_low, vs_low, eol_bad;
  int hs_cnt[8], hs_first[8], bl_low[8], vs_cnt[8], eol_cnt[8];
  int ly, lx;

  initial begin
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_h     = '0;
    cfg_if.i_cfg_v     = '0;
    cfg_if.i_cfg_pol   = 2'b00;
    rst_vec = {1'b0, 1'b0, 1'b1, H_W'(0), V_W'(0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("reset_state", obs_vec, rst_vec);
    i_en = 1'b1;
    i_arst_n = 1'b1;

    // Default raster: frame period and per-line waveform
    sof_period(per);
    chk("sof_period_a", per, 128);
    sof_period(per);
    chk("sof_period_b", per, 128);
    for (int l = 0; l < 8; l++) begin
      hs_cnt[l] = 0; hs_first[l] = -1; bl_low[l] = 0; vs_cnt[l] = 0; eol_cnt[l] = 0;
    end
    eol_bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) @(negedge i_clk);
      ly = int'(o_y) & 7;
      lx = int'(o_x);
      if (o_hsync) begin
        hs_cnt[ly]++;
        if (hs_first[ly] < 0) hs_first[ly] = lx;
      end
      if (!o_blank) bl_low[ly]++;
      if (o_vsync) vs_cnt[ly]++;
      if (o_eol) begin
        eol_cnt[ly]++;
        if (lx != 7) eol_bad++;
      end
    end
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("hs_cnt_l%0d", l), hs_cnt[l], 3);
      chk($sformatf("hs_first_l%0d", l), hs_first[l], 10);
      chk($sformatf("blank_low_l%0d", l), bl_low[l], (l < 4) ? 8 : 0);
      chk($sformatf("vs_cnt_l%0d", l), vs_cnt[l], (l == 5) ? 16 : 0);
      chk($sformatf("eol_cnt_l%0d", l), eol_cnt[l], (l < 4) ? 1 : 0);
    end
    chk("eol_off_x7", eol_bad, 0);

    // Enable dropped with the counter at h=5, v=2
    wait_xy("reach_h5_v2", 4, 2, 300);
    i_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      chk("en_hold", {o_x, o_blank, o_hsync, o_vsync, o_sof, o_eol},
          {H_W'(5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    i_en = 1'b1;
    @(negedge i_clk);
    chk("en_resume_first", {o_x, o_blank}, {H_W'(5), 1'b0});
    @(negedge i_clk);
    chk("en_resume_x6", o_x, 6);

    // Rejected requests: sync=0, H_TOT>4096, V_TOT>2048
    eh_tab[0] = pack_h(8, 2, 0, 3);      ev_tab[0] = pack_v(4, 1, 1, 2);
    eh_tab[1] = pack_h(4000, 50, 40, 10); ev_tab[1] = pack_v(4, 1, 1, 2);
    eh_tab[2] = pack_h(8, 2, 3, 3);      ev_tab[2] = pack_v(2000, 20, 20, 10);
    for (int k = 0; k < 3; k++) begin
      send_cfg(eh_tab[k], ev_tab[k], 2'b00);
      chk($sformatf("rej%0d_pulse", k),
          {cfg_if.o_cfg_err, cfg_if.o_cfg_pending, cfg_if.o_cfg_ready}, 3'b101);
      @(negedge i_clk);
      chk($sformatf("rej%0d_once", k),
          {cfg_if.o_cfg_err, cfg_if.o_cfg_pending, cfg_if.o_cfg_ready}, 3'b001);
    end
    sof_period(per);
    chk("rej_timing_kept", per, 128);

    // Mid-frame mode change to H 4/1/1/2, V 2/1/1/1, active-low syncs
    wait_xy("reach_mid_frame", 0, 2, 300);
    send_cfg(pack_h(4, 1, 1, 2), pack_v(2, 1, 1, 1), 2'b00);
    chk("cfg_taken", {cfg_if.o_cfg_ready, cfg_if.o_cfg_pending, cfg_if.o_cfg_err}, 3'b010);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_x == H_W'(15) && o_y == V_W'(7)) break;
      if (!cfg_if.o_cfg_pending || cfg_if.o_cfg_ready) bad++;
    end
    chk("pend_until_frame_end", bad, 0);
    chk("apply_at_last_pixel", {o_x, o_y, cfg_if.o_cfg_ready, cfg_if.o_cfg_pending},
        {H_W'(15), V_W'(7), 1'b1, 1'b0});
    @(negedge i_clk);
    chk("new_frame_sof", {o_sof, o_x, o_y}, {1'b1, H_W'(0), V_W'(0)});
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge i_clk);
      if (!o_hsync) hs_low++;
      if (!o_vsync) vs_low++;
    end
    chk("new_hs_low", hs_low, 5);
    chk("new_vs_low", vs_low, 8);
    @(negedge i_clk);
    chk("new_period_40", o_sof, 1);
    sof_period(per);
    chk("new_sof_period", per, 40);

    // Reset mid-line with a request pending
    wait_xy("reach_mid_line", 2, 1, 100);
    send_cfg(pack_h(6, 1, 1, 1), pack_v(3, 1, 1, 1), 2'b01);
    chk("second_cfg_pending", cfg_if.o_cfg_pending, 1);
    @(negedge i_clk);
    #2 i_arst_n = 1'b0;
    #1 chk("async_reset", obs_vec, rst_vec);
    @(negedge i_clk);
    i_arst_n = 1'b1;
    sof_period(per);
    chk("default_resume", per, 128);
    chk("shadow_dropped", cfg_if.o_cfg_pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    fails++;
    $display("FAIL timeout: run did not complete, observed still running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
